// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: PS/2 keyboard receiver with scan-code prefix decoding.
// Synchronizes the raw PS/2 clock and data lines and frames 11-bit words
// (start, 8 data LSB first, parity, stop). It folds E0/F0 prefixes into
// ext/brk flags and presents one held event to a consumer.
// Handshake: key_valid stays high and the event fields stay stable until
// the consumer raises key_ack while key_valid=1. key_valid then drops on the
// next clock, unless a new event loads on that same edge. An event that
// arrives while one is held and not acknowledged is dropped and flagged by
// a one-cycle overflow pulse.
// Optional feature: define PS2_PARITY_CHECK_EN to enforce odd parity;
// without it the parity bit is consumed and ignored.
module ps2_scan_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       key_ack,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err,
  output logic       overflow
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_break_q, key_break_d;
  logic          key_ext_q, key_ext_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic          fall;
  logic          par_ok;
  logic          emit;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  // Data bits plus parity bit must hold an odd number of ones.
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // Falling edge of the synchronized PS/2 clock.
  assign fall = clk_prev_q & ~clk_s2_q;

  // Next-state logic for the receiver, prefix flags, timeout and event buffer.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_cnt_d    = to_cnt_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_break_d = key_break_q;
    key_ext_d   = key_ext_q;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    emit        = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d       = par_q;
`endif

    if (fall) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_s2_q;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q && par_ok) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              emit  = 1'b1;
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // Abort a frame whose keyboard clock has gone quiet.
      if (to_cnt_q == TO_LAST) begin
        state_d     = IDLE;
        frame_err_d = 1'b1;
        ext_d       = 1'b0;
        brk_d       = 1'b0;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end

    // Event buffer: an ack on the emit edge frees the slot for the new event.
    if (emit) begin
      if (!key_valid_q || key_ack) begin
        key_valid_d = 1'b1;
        key_code_d  = shift_q;
        key_break_d = brk_q;
        key_ext_d   = ext_q;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (key_valid_q && key_ack) begin
      key_valid_d = 1'b0;
    end
  end

  // State registers, synchronizers and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'd0;
      key_break_q <= 1'b0;
      key_ext_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_s1_q    <= PS2_CLK;
      clk_s2_q    <= clk_s1_q;
      clk_prev_q  <= clk_s2_q;
      dat_s1_q    <= PS2_DAT;
      dat_s2_q    <= dat_s1_q;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_break_q <= key_break_d;
      key_ext_q   <= key_ext_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_break = key_break_q;
  assign key_ext   = key_ext_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb_ps2_scan_ctrl: directed bench for ps2_scan_ctrl (short timeout).
module tb_ps2_scan_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic       key_ack  = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       frame_err;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  ps2_scan_ctrl #(.TIMEOUT_CYCLES(200)) dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .key_ack   (key_ack),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_break (key_break),
    .key_ext   (key_ext),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // 50 MHz clock
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set up, clock low for 10 cycles, clock high again.
  task automatic ps2_bit(input logic b);
    @(negedge CLOCK_50);
    PS2_DAT = b;
    repeat (5) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  // Start, data, parity; returns just after the stop-bit clock falls.
  task automatic send_to_stop(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(bad_par ? ^b : ~^b);
    @(negedge CLOCK_50);
    PS2_DAT = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
  endtask

  task automatic stop_release();
    repeat (10) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_to_stop(b, 1'b0);
    stop_release();
  endtask

  task automatic do_ack();
    @(negedge CLOCK_50);
    key_ack = 1'b1;
    @(negedge CLOCK_50);
    key_ack = 1'b0;
  endtask

  int err_cycles;
  int first_err;

  initial begin
    // Reset values
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 8'h00);
    chk("rst_break", key_break, 0);
    chk("rst_ext", key_ext, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge CLOCK_50);
    Resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    // Plain make code 1C: latency and hold
    send_to_stop(8'h1C, 1'b0);
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    chk("1c_early_valid", key_valid, 0);
    @(posedge CLOCK_50); #1;
    chk("1c_valid", key_valid, 1);
    chk("1c_code", key_code, 8'h1C);
    chk("1c_break", key_break, 0);
    chk("1c_ext", key_ext, 0);
    stop_release();
    repeat (20) @(negedge CLOCK_50);
    chk("1c_hold_valid", key_valid, 1);
    chk("1c_hold_code", key_code, 8'h1C);
    do_ack();
    chk("1c_ack_clears", key_valid, 0);

    // Break code F0 1C
    send_frame(8'hF0);
    chk("f0_no_event", key_valid, 0);
    send_frame(8'h1C);
    chk("brk_valid", key_valid, 1);
    chk("brk_code", key_code, 8'h1C);
    chk("brk_break", key_break, 1);
    chk("brk_ext", key_ext, 0);
    do_ack();

    // Extended break E0 F0 75
    send_frame(8'hE0);
    send_frame(8'hF0);
    chk("e0f0_no_event", key_valid, 0);
    send_frame(8'h75);
    chk("ext_valid", key_valid, 1);
    chk("ext_code", key_code, 8'h75);
    chk("ext_break", key_break, 1);
    chk("ext_ext", key_ext, 1);
    do_ack();
    chk("ext_ack_clears", key_valid, 0);

    // Wrong parity
    send_to_stop(8'h1C, 1'b1);
    @(posedge CLOCK_50); @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err_pulse", frame_err, 1);
    chk("par_no_event", key_valid, 0);
    @(posedge CLOCK_50); #1;
    chk("par_err_single", frame_err, 0);
    stop_release();
`else
    chk("par_ignored_err", frame_err, 0);
    chk("par_ignored_valid", key_valid, 1);
    chk("par_ignored_code", key_code, 8'h1C);
    stop_release();
    do_ack();
`endif

    // Overflow: 1C held, 32 dropped
    send_frame(8'h1C);
    send_to_stop(8'h32, 1'b0);
    @(posedge CLOCK_50); @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    chk("ovf_pulse", overflow, 1);
    chk("ovf_code_kept", key_code, 8'h1C);
    chk("ovf_valid", key_valid, 1);
    @(posedge CLOCK_50); #1;
    chk("ovf_single", overflow, 0);
    stop_release();

    // Ack on the same edge the 32 event loads
    send_to_stop(8'h32, 1'b0);
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    key_ack = 1'b1;
    @(posedge CLOCK_50); #1;
    key_ack = 1'b0;
    chk("ackemit_valid", key_valid, 1);
    chk("ackemit_code", key_code, 8'h32);
    chk("ackemit_ovf", overflow, 0);
    stop_release();
    chk("ackemit_still_valid", key_valid, 1);
    do_ack();
    chk("ackemit_cleared", key_valid, 0);

    // Ack with nothing held is ignored
    do_ack();
    chk("idle_ack_valid", key_valid, 0);

    // Timeout: F0 prefix, then a frame that stalls after 4 data bits
    send_frame(8'hF0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    err_cycles = 0;
    first_err  = -1;
    for (int c = 0; c < 400; c++) begin
      @(posedge CLOCK_50); #1;
      if (frame_err === 1'b1) begin
        err_cycles++;
        if (first_err < 0) first_err = c;
      end
    end
    chk("to_err_count", 8'(err_cycles), 8'd1);
    chk("to_not_early", 8'(first_err >= 150), 8'd1);
    chk("to_no_event", key_valid, 0);
    send_frame(8'h24);
    chk("to_next_valid", key_valid, 1);
    chk("to_next_code", key_code, 8'h24);
    chk("to_next_break", key_break, 0);
    chk("to_next_ext", key_ext, 0);
    do_ack();

    // Reset mid-frame after E0 with an event held
    send_frame(8'h1C);
    send_frame(8'hE0);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    @(negedge CLOCK_50);
    Resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("mrst_valid", key_valid, 0);
    chk("mrst_code", key_code, 8'h00);
    Resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    send_frame(8'h6B);
    chk("mrst_6b_valid", key_valid, 1);
    chk("mrst_6b_code", key_code, 8'h6B);
    chk("mrst_6b_ext", key_ext, 0);
    chk("mrst_6b_break", key_break, 0);
    do_ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #20ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_scan_ctrl.md
PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning idle-gap limit in CLOCK_50 cycles before an in-progress frame aborts.
REQ-002 The module SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-003 The module SHALL have port Resetn  input  1  reset, synchronous, active-low.
REQ-004 The module SHALL have port PS2_CLK  input  1  raw keyboard clock, asynchronous.
REQ-005 The module SHALL have port PS2_DAT  input  1  raw keyboard data, asynchronous.
REQ-006 The module SHALL have port key_ack  input  1  consumer accepts the held event.
REQ-007 The module SHALL have port key_valid  output  1  event held.
REQ-008 The module SHALL have port key_code  output  8  scan code, prefixes stripped.
REQ-009 The module SHALL have port key_break  output  1  event preceded by F0 (release).
REQ-010 The module SHALL have port key_ext  output  1  event preceded by E0 (extended).
REQ-011 The module SHALL have port frame_err  output  1  one-cycle pulse on a bad or aborted frame.
REQ-012 The module SHALL have port overflow  output  1  one-cycle pulse when an event is dropped.

Function
REQ-013 The module SHALL pass PS2_CLK and PS2_DAT through two-flop synchronizers; a falling edge SHALL be synchronized clock 1 in the previous cycle and 0 in the current cycle.
REQ-014 The receiver FSM SHALL have states IDLE, DATA, PARITY, STOP and SHALL advance only on a falling edge.
REQ-015 IDLE: DAT=0 -> DATA with bit count 0; DAT=1 -> stay IDLE, no error.
REQ-016 DATA: shift DAT in, LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: sample the parity bit -> STOP.
REQ-018 STOP: always -> IDLE; the frame SHALL be accepted only if DAT=1 and the parity check passes (REQ-030), otherwise frame_err SHALL pulse and the byte SHALL be discarded.
REQ-019 Accepted byte E0 SHALL set an internal ext flag, and F0 SHALL set an internal brk flag; neither SHALL emit an event.
REQ-020 Any other accepted byte SHALL emit an event {ext, brk, byte}, then clear both flags.
REQ-021 An emitted event SHALL appear on key_valid/key_code/key_break/key_ext in the cycle after the stop-bit edge is detected.
REQ-022 Outputs SHALL hold while key_valid=1 and key_ack=0; key_ack=1 with key_valid=1 SHALL clear key_valid next cycle.
REQ-023 If an event is emitted while key_valid=1 and key_ack=0, the held event SHALL be kept, the new event dropped, and overflow SHALL pulse.
REQ-024 If an event is emitted in the same cycle as an ack, the new event SHALL load and key_valid SHALL stay 1.
REQ-025 key_ack while key_valid=0 SHALL be ignored.
REQ-026 The timeout counter SHALL clear on every falling edge and SHALL count in states other than IDLE; reaching TIMEOUT_CYCLES-1 SHALL force IDLE, pulse frame_err, and clear ext/brk.
REQ-027 Any frame_err SHALL clear ext and brk.

Reset
REQ-028 With Resetn=0 at a clock edge: FSM IDLE, counters 0, shift register 0, flags 0, synchronizers and edge history 1, and key_valid, key_code, key_break, key_ext, frame_err, overflow all 0.
REQ-029 Reset asserted mid-frame or with an event held SHALL discard everything; the first falling edge after release SHALL be treated as a potential start bit.

Configuration
REQ-030 With macro PS2_PARITY_CHECK_EN defined, the module SHALL require odd parity over the 8 data bits plus the parity bit, and a mismatch SHALL cause frame_err; without it, the parity bit SHALL be sampled and ignored.

Verification
REQ-031 Send frame 0x1C with correct parity and stop=1 -> key_valid=1, key_code=0x1C, key_break=0, key_ext=0 one cycle after the stop edge; hold until ack.
REQ-032 Send bytes F0 then 1C -> single event key_code=0x1C, key_break=1; send E0, F0, 75 -> key_code=0x75, key_ext=1, key_break=1.
REQ-033 Send 0x1C with wrong parity (macro defined) -> frame_err single pulse, no event; without the macro -> event 0x1C.
REQ-034 Send 0x1C with no ack, then 0x32 -> overflow pulse, key_code stays 0x1C; ack in the same cycle as the 0x32 emit -> key_code=0x32, key_valid stays 1.
REQ-035 Stop PS2_CLK after 4 data bits for TIMEOUT_CYCLES cycles -> frame_err pulse, FSM IDLE; next full frame 0x24 -> event 0x24 with no prefix flags.
REQ-036 Assert Resetn=0 mid-frame after an E0 prefix, then send 0x6B -> key_code=0x6B, key_ext=0.
